// File: rtl/alu16_nibble_sequencer.sv
// alu16_nibble_sequencer: nibble-serial ALU that pushes a W-bit operation through one 74181 slice,
// LSB nibble first, with valid/ready handshakes on both the operation and the result.
module alu_74181 (
    input  logic [3:0] sel,
    input  logic       mode,
    input  logic       c_in,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] f,
    output logic       c_out,
    output logic       equal
);
    logic [3:0] e;
    logic [3:0] d;
    logic [4:0] c;
    assign e = ~((a & b & {4{sel[3]}}) | (a & ~b & {4{sel[2]}}));
    assign d = ~(a | (~b & {4{sel[1]}}) | (b & {4{sel[0]}}));
    // c is the internal active-high carry; the pins use the inverted convention
    always_comb begin
        c[0] = ~c_in;
        for (int i = 0; i < 4; i++) c[i+1] = ~e[i] | (~d[i] & c[i]);
    end
    assign f     = ~(e ^ d) ^ ({4{~mode}} & ~c[3:0]);
    assign c_out = ~c[4];
    assign equal = &f;
endmodule

module alu16_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           sel,
    input  logic                 mode,
    input  logic                 c_in,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] f,
    output logic                 c_out,
    output logic                 equal,
    output logic                 busy
);
    localparam int W = 4 * NIBBLES;
    localparam int NW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [NW-1:0] nib;
    logic [3:0]    sel_q;
    logic          mode_q;
    logic [W-1:0]  a_q, b_q, f_q;
    logic          carry, eq_acc;
    logic [3:0]    s_f;
    logic          s_cout, s_eq, last;
    alu_74181 u_slice (
        .sel   (sel_q),
        .mode  (mode_q),
        .c_in  (carry),
        .a     (a_q[4*nib +: 4]),
        .b     (b_q[4*nib +: 4]),
        .f     (s_f),
        .c_out (s_cout),
        .equal (s_eq)
    );
    assign last = nib == NW'(NIBBLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        case (state)
            IDLE:    state_nx = in_valid ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            mode_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            f_q    <= '0;
            carry  <= 1'b1;
            eq_acc <= 1'b0;
            nib    <= '0;
        end else if (state == IDLE && in_valid) begin
            sel_q  <= sel;
            mode_q <= mode;
            a_q    <= a;
            b_q    <= b;
            f_q    <= '0;
            carry  <= c_in;
            eq_acc <= 1'b1;
            nib    <= '0;
        end else if (state == RUN) begin
            f_q[4*nib +: 4] <= s_f;
            carry           <= s_cout;
            eq_acc          <= eq_acc & s_eq;
            nib             <= last ? nib : nib + 1'b1;
        end
    end
    assign f     = f_q;
    assign c_out = carry;
    assign equal = eq_acc;
endmodule

// File: tb/tb_alu16_nibble_sequencer.sv
// tb_alu16_nibble_sequencer: directed vectors with hand-computed results for the nibble-serial ALU.
module tb_alu16_nibble_sequencer;
    logic        clk, rst_n, in_valid, in_ready, mode, c_in, out_valid, out_ready, c_out, equal, busy;
    logic [3:0]  sel;
    logic [15:0] a, b, f;
    int total = 0;
    int bad = 0;
    logic [15:0] rf, hf;
    logic        rc, re, hc, he;
    int          n, acc_idx, res_idx, last_acc, cyc;
    logic [15:0] tp_a [3];
    logic [15:0] tp_b [3];
    logic [15:0] tp_f [3];

    alu16_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .c_in      (c_in),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .c_out     (c_out),
        .equal     (equal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] s, input logic m, input logic ci, input logic [15:0] x,
                          input logic [15:0] y, output logic [15:0] of, output logic oc, output logic oe);
        int k;
        @(negedge clk);
        sel = s; mode = m; c_in = ci; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, 4);
        of = f; oc = c_out; oe = equal;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = '0; mode = 1'b0; c_in = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_f", f, 0);
        check("rst_c_out", c_out, 1);
        check("rst_equal", equal, 0);
        @(negedge clk); rst_n = 1'b1;

        // reset mid-RUN after two nibbles of 0x1111+0x1111
        @(negedge clk);
        sel = 4'b1001; mode = 1'b0; c_in = 1'b1; a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_f_partial", f, 16'h0022);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_f", f, 0);
        check("mrst_c_out", c_out, 1);
        check("mrst_equal", equal, 0);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("mrst_no_valid", n, 0);

        run_op(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001, rf, rc, re);
        check("add_ripple_f", rf, 16'h0100);
        check("add_ripple_c", rc, 1);
        run_op(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, rf, rc, re);
        check("add_wrap_f", rf, 16'h0000);
        check("add_wrap_c", rc, 0);
        run_op(4'b0110, 1'b0, 1'b0, 16'h1234, 16'h0234, rf, rc, re);
        check("sub_f", rf, 16'h1000);
        check("sub_c", rc, 0);
        run_op(4'b0110, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, rf, rc, re);
        check("cmp_eq_f", rf, 16'hFFFF);
        check("cmp_eq_equal", re, 1);
        check("cmp_eq_c", rc, 1);
        run_op(4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0003, rf, rc, re);
        check("cmp_gt_f", rf, 16'h0001);
        check("cmp_gt_equal", re, 0);
        check("cmp_gt_c", rc, 0);
        run_op(4'b1011, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, rf, rc, re);
        check("and_f", rf, 16'hF000);
        run_op(4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, rf, rc, re);
        check("xor_f", rf, 16'h0FF0);

        // backpressure plus input disturbance during RUN
        @(negedge clk);
        sel = 4'b1001; mode = 1'b0; c_in = 1'b1; a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sel = 4'b0000; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid", out_valid, 1);
        hf = f; hc = c_out; he = equal;
        check("bp_f", hf, 16'h2345);
        check("bp_c", hc, 1);
        check("bp_equal", he, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (f !== hf || c_out !== hc || equal !== he || in_ready !== 1'b0 || out_valid !== 1'b1) n++;
        end
        check("bp_stable", n, 0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("bp_release", in_ready, 1);
        check("bp_hold_idle", f, 16'h2345);

        // throughput: in_valid and out_ready held high
        tp_a[0] = 16'h1111; tp_b[0] = 16'h2222; tp_f[0] = 16'h3333;
        tp_a[1] = 16'h0FFF; tp_b[1] = 16'h0001; tp_f[1] = 16'h1000;
        tp_a[2] = 16'h8000; tp_b[2] = 16'h8000; tp_f[2] = 16'h0000;
        sel = 4'b1001; mode = 1'b0; c_in = 1'b1;
        acc_idx = 0; res_idx = 0; last_acc = 0; cyc = 0;
        out_ready = 1'b1;
        while (res_idx < 3 && cyc < 60) begin
            @(negedge clk);
            if (out_valid) begin
                check($sformatf("tp_f%0d", res_idx), f, tp_f[res_idx]);
                res_idx++;
            end
            if (in_ready) begin
                if (acc_idx < 3) begin
                    a = tp_a[acc_idx]; b = tp_b[acc_idx]; in_valid = 1'b1;
                    if (acc_idx > 0) check($sformatf("tp_gap%0d", acc_idx), cyc - last_acc, 6);
                    last_acc = cyc;
                    acc_idx++;
                end else in_valid = 1'b0;
            end
            cyc++;
        end
        check("tp_results", res_idx, 3);
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
